// File: rtl/d_a_bist_if.sv
`default_nettype none
// ============================================================================
//  Module      : d_a_bist_if
//  Description : Signal bundle between the d_a_bist stimulus/checker and its
//                controller. The BIST block uses the slave modport (it receives
//                start and the DUT's Y, and drives A/B/C plus status). The
//                controller side uses the master modport.
//                Optional macro D_A_BIST_INJECT_EN adds inject_i.
//  Revision    : 1.0 - initial release
// ============================================================================
interface d_a_bist_if #(
    parameter int ERR_CNT_W = 4
);
    logic                 start;
    logic                 y_i;
    logic                 a_o;
    logic                 b_o;
    logic                 c_o;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [ERR_CNT_W-1:0] err_count;
    logic [7:0]           fail_vec;
`ifdef D_A_BIST_INJECT_EN
    logic                 inject_i;

    modport slave (
        input  start, y_i, inject_i,
        output a_o, b_o, c_o, busy, done, pass, err_count, fail_vec
    );
    modport master (
        output start, y_i, inject_i,
        input  a_o, b_o, c_o, busy, done, pass, err_count, fail_vec
    );
`else
    modport slave (
        input  start, y_i,
        output a_o, b_o, c_o, busy, done, pass, err_count, fail_vec
    );
    modport master (
        output start, y_i,
        input  a_o, b_o, c_o, busy, done, pass, err_count, fail_vec
    );
`endif
endinterface
`default_nettype wire

// File: rtl/d_a_bist.sv
`default_nettype none
// ============================================================================
//  Module      : d_a_bist
//  Description : On-chip stimulus generator and response checker for the
//                block Y = (~A & B) | (A & ~C). Sweeps A/B/C through all eight
//                patterns, holds each for SETTLE_CYCLES, samples Y and compares
//                it against a built-in golden function. Reports pass, a
//                saturating error count and a per-pattern fail map.
//                Optional macro D_A_BIST_INJECT_EN: inject_i inverts the
//                golden value during a CHECK cycle to exercise the fail path.
//  Revision    : 1.0 - initial release
// ============================================================================
module d_a_bist #(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_CNT_W     = 4
) (
    input  wire logic   clk,
    input  wire logic   rst,
    d_a_bist_if.slave   bus
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SETTLE = 2'd1;
    localparam logic [1:0] c_CHECK  = 2'd2;
    localparam logic [1:0] c_DONE   = 2'd3;

    localparam logic [7:0]           c_LAST_CNT = 8'(SETTLE_CYCLES - 1);
    localparam logic [ERR_CNT_W-1:0] c_ERR_MAX  = '1;

    logic [1:0]           state_q, state_d;
    logic [2:0]           idx_q,   idx_d;
    logic [7:0]           cnt_q,   cnt_d;
    logic [ERR_CNT_W-1:0] err_q,   err_d;
    logic [7:0]           fv_q,    fv_d;
    logic                 pass_q,  pass_d;

    logic w_exp;
    logic w_exp_cmp;
    logic w_mismatch;

    // Golden response for the pattern currently applied (1 for idx 2,3,4,6)
    always_comb begin
        w_exp = (~idx_q[2] & idx_q[1]) | (idx_q[2] & ~idx_q[0]);
    end

`ifdef D_A_BIST_INJECT_EN
    // Inverting the golden value forces a mismatch on a healthy DUT
    always_comb begin
        w_exp_cmp = w_exp ^ bus.inject_i;
    end
`else
    // No injection path: compare against the plain golden value
    always_comb begin
        w_exp_cmp = w_exp;
    end
`endif

    // Y is treated as binary; any difference is one mismatch
    always_comb begin
        w_mismatch = (bus.y_i != w_exp_cmp);
    end

    // Sweep sequencing and result accumulation
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        fv_d    = fv_q;
        pass_d  = pass_q;
        case (state_q)
            c_IDLE: begin
                if (bus.start) begin
                    err_d   = '0;
                    fv_d    = '0;
                    idx_d   = '0;
                    cnt_d   = '0;
                    pass_d  = 1'b0;
                    state_d = c_SETTLE;
                end
            end
            c_SETTLE: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == c_LAST_CNT) begin
                    state_d = c_CHECK;
                end
            end
            c_CHECK: begin
                if (w_mismatch) begin
                    if (err_q != c_ERR_MAX) begin
                        err_d = err_q + 1'b1;
                    end
                    fv_d[idx_q] = 1'b1;
                end
                if (idx_q == 3'd7) begin
                    // Include the final compare so pass is valid with done
                    pass_d  = (err_d == '0);
                    state_d = c_DONE;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    cnt_d   = '0;
                    state_d = c_SETTLE;
                end
            end
            c_DONE: begin
                idx_d   = '0;
                state_d = c_IDLE;
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            fv_q    <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            fv_q    <= fv_d;
            pass_q  <= pass_d;
        end
    end

    assign bus.a_o       = idx_q[2];
    assign bus.b_o       = idx_q[1];
    assign bus.c_o       = idx_q[0];
    assign bus.busy      = (state_q == c_SETTLE) || (state_q == c_CHECK);
    assign bus.done      = (state_q == c_DONE);
    assign bus.pass      = pass_q;
    assign bus.err_count = err_q;
    assign bus.fail_vec  = fv_q;

endmodule
`default_nettype wire

// File: tb/tb_d_a_bist.sv
`default_nettype none
// ============================================================================
//  Module      : tb_d_a_bist
//  Description : Self-checking bench for d_a_bist. A behavioural DUT model
//                (correct, stuck-0, stuck-1, inverted) feeds y_i; expected
//                run results are queued when a run is started and compared
//                when done pulses. A second instance with ERR_CNT_W=2 checks
//                error-count saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_d_a_bist;

    localparam int S       = 2;
    localparam int LATENCY = 8 * (S + 1);   // negedges from accept to done
    localparam int PERIOD  = 8 * (S + 1) + 2;

    typedef struct {
        logic [7:0] fv;
        logic [3:0] ec;
        logic       ps;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    d_a_bist_if #(.ERR_CNT_W(4)) bus ();
    d_a_bist_if #(.ERR_CNT_W(2)) bus2 ();

    d_a_bist #(.SETTLE_CYCLES(S), .ERR_CNT_W(4)) dut  (.clk(clk), .rst(rst), .bus(bus));
    d_a_bist #(.SETTLE_CYCLES(S), .ERR_CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    int n_checks = 0;
    int n_fail   = 0;
    int mode     = 0;
    exp_t sb[$];

    // Reference truth table written from the listed 1-patterns
    function automatic logic golden(input logic [2:0] i);
        return (i == 3'd2) || (i == 3'd3) || (i == 3'd4) || (i == 3'd6);
    endfunction

    function automatic logic dut_model(input int m, input logic [2:0] i);
        case (m)
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return ~golden(i);
            default: return golden(i);
        endcase
    endfunction

    function automatic exp_t make_exp(input int m, input int inj_idx);
        exp_t e;
        int   errs = 0;
        e.fv = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (dut_model(m, 3'(i)) != (golden(3'(i)) ^ (i == inj_idx))) begin
                e.fv[i] = 1'b1;
                errs++;
            end
        end
        e.ec = (errs > 15) ? 4'd15 : 4'(errs);
        e.ps = (errs == 0);
        return e;
    endfunction

    assign bus.y_i  = dut_model(mode, {bus.a_o, bus.b_o, bus.c_o});
    assign bus2.y_i = ~golden({bus2.a_o, bus2.b_o, bus2.c_o});

`ifdef D_A_BIST_INJECT_EN
    logic inj_en = 1'b0;
    assign bus.inject_i  = inj_en && ({bus.a_o, bus.b_o, bus.c_o} == 3'd5);
    assign bus2.inject_i = 1'b0;
`endif

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Monitor: tracks accepts, the A/B/C sweep and scores each done pulse
    int         cyc       = 0;
    int         acc_cyc   = 0;
    int         done_cnt  = 0;
    int         last_done = -1;
    bit         b2b       = 1'b0;
    bit         prev_idle = 1'b0;
    bit         first     = 1'b0;
    bit         step_bad  = 1'b0;
    logic [2:0] prev_abc  = 3'd0;
    int         max_abc   = 0;

    always @(negedge clk) begin
        logic [2:0] abc;
        exp_t       e;
        cyc++;
        abc = {bus.a_o, bus.b_o, bus.c_o};
        if (!rst) begin
            // start seen now was sampled by the edge just past, where the
            // DUT was in the state observed at the previous negedge
            if (prev_idle && bus.start) begin
                acc_cyc  = cyc;
                first    = 1'b1;
                step_bad = 1'b0;
                max_abc  = 0;
            end
            if (bus.busy) begin
                if (first) begin
                    if (abc != 3'd0) step_bad = 1'b1;
                    first = 1'b0;
                end else if (abc != prev_abc && abc != prev_abc + 3'd1) begin
                    step_bad = 1'b1;
                end
                prev_abc = abc;
                if (int'(abc) > max_abc) max_abc = int'(abc);
            end
            if (bus.done) begin
                done_cnt++;
                check_eq("sb_has_entry", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check_eq("fail_vec",     32'(bus.fail_vec),  32'(e.fv));
                    check_eq("err_count",    32'(bus.err_count), 32'(e.ec));
                    check_eq("pass",         32'(bus.pass),      32'(e.ps));
                    check_eq("done_latency", 32'(cyc - acc_cyc), 32'(LATENCY));
                    check_eq("abc_steps",    32'(step_bad),      32'd0);
                    check_eq("abc_max",      32'(max_abc),       32'd7);
                end
                if (b2b && last_done >= 0) begin
                    check_eq("done_spacing", 32'(cyc - last_done), 32'(PERIOD));
                end
                last_done = cyc;
            end
        end
        prev_idle = !bus.busy && !bus.done;
    end

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            #2;
            n++;
        end
        check_eq("done_seen", 32'(done_cnt >= target), 32'd1);
    endtask

    task automatic run(input int m, input int inj);
        int tgt;
        mode = m;
        sb.push_back(make_exp(m, inj));
        tgt = done_cnt + 1;
        @(negedge clk); #1 bus.start = 1'b1;
        @(negedge clk); #1 bus.start = 1'b0;
        wait_done(tgt, 80);
    endtask

    initial begin
        int tgt;
        int n;
        int dc;
        bus.start  = 1'b0;
        bus2.start = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 32'(bus.busy),      32'd0);
        check_eq("rst_done", 32'(bus.done),      32'd0);
        check_eq("rst_pass", 32'(bus.pass),      32'd0);
        check_eq("rst_err",  32'(bus.err_count), 32'd0);
        check_eq("rst_fv",   32'(bus.fail_vec),  32'd0);
        check_eq("rst_abc",  32'({bus.a_o, bus.b_o, bus.c_o}), 32'd0);
        #1 rst = 1'b0;

        // Correct, stuck-0, stuck-1, fully inverted DUT
        run(0, -1);
        run(1, -1);
        run(2, -1);
        run(3, -1);

        // A start pulse mid-run must not restart the sweep
        mode = 0;
        sb.push_back(make_exp(0, -1));
        tgt = done_cnt + 1;
        @(negedge clk); #1 bus.start = 1'b1;
        @(negedge clk); #1 bus.start = 1'b0;
        repeat (10) @(negedge clk);
        #1 bus.start = 1'b1;
        @(negedge clk); #1 bus.start = 1'b0;
        wait_done(tgt, 80);

        // Narrow error counter saturates
        @(negedge clk); #1 bus2.start = 1'b1;
        @(negedge clk); #1 bus2.start = 1'b0;
        n = 0;
        while (!bus2.done && n < 80) begin
            @(negedge clk);
            n++;
        end
        check_eq("w2_done",  32'(bus2.done),      32'd1);
        check_eq("w2_err",   32'(bus2.err_count), 32'd3);
        check_eq("w2_fv",    32'(bus2.fail_vec),  32'hFF);
        check_eq("w2_pass",  32'(bus2.pass),      32'd0);

        // Reset while idx=3 aborts without a done pulse
        mode = 1;
        sb.push_back(make_exp(1, -1));
        dc = done_cnt;
        @(negedge clk); #1 bus.start = 1'b1;
        @(negedge clk); #1 bus.start = 1'b0;
        n = 0;
        while ({bus.a_o, bus.b_o, bus.c_o} != 3'd3 && n < 80) begin
            @(negedge clk); #2;
            n++;
        end
        check_eq("abort_reached_idx3", 32'({bus.a_o, bus.b_o, bus.c_o}), 32'd3);
        rst = 1'b1;
        @(negedge clk); #1 rst = 1'b0;
        check_eq("abort_busy", 32'(bus.busy),      32'd0);
        check_eq("abort_abc",  32'({bus.a_o, bus.b_o, bus.c_o}), 32'd0);
        check_eq("abort_err",  32'(bus.err_count), 32'd0);
        check_eq("abort_done", 32'(bus.done),      32'd0);
        sb.delete();
        repeat (30) @(negedge clk);
        #2;
        check_eq("abort_no_done", 32'(done_cnt), 32'(dc));
        run(0, -1);

`ifdef D_A_BIST_INJECT_EN
        // Injected compare at pattern 5 on a correct DUT
        inj_en = 1'b1;
        run(0, 5);
        inj_en = 1'b0;
`endif

        // start held high: back-to-back runs one IDLE cycle apart
        mode = 0;
        repeat (3) sb.push_back(make_exp(0, -1));
        tgt = done_cnt + 3;
        b2b = 1'b1;
        last_done = -1;
        @(negedge clk); #1 bus.start = 1'b1;
        repeat (60) @(negedge clk);
        #1 bus.start = 1'b0;
        wait_done(tgt, 80);
        repeat (4) @(negedge clk);
        #2;
        check_eq("b2b_run_count", 32'(done_cnt), 32'(tgt));
        b2b = 1'b0;

        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
